// File: rtl/host_mem_resp_model.sv
// Memory-end responder for the host memory request mux: byte-masked writes, fixed-latency in-order reads.
// Reads capture write-first at accept; return path has no backpressure, issue throttled by outstanding count.
module host_mem_resp_model #(
  parameter int DATA_WIDTH      = 512,
  parameter int ADDR_WIDTH      = 64,
  parameter int MASK_WIDTH      = DATA_WIDTH / 8,
  parameter int DEPTH           = 1024,
  parameter int RD_LATENCY      = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [MASK_WIDTH-1:0] wr_datastrb,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  wr_cmd_rdy,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_cmd_rdy,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_vld,
  input  logic                  wr_stall,
  input  logic                  rd_stall,
  output logic [31:0]           wr_cnt,
  output logic [31:0]           rd_cnt
);

  localparam int OFF   = $clog2(MASK_WIDTH);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] pipe_dat [RD_LATENCY];
  logic [RD_LATENCY-1:0] pipe_vld;
  logic [OUT_W-1:0]      outstanding;
  logic                  rst_q;
  logic [IDX_W-1:0]      widx;
  logic [IDX_W-1:0]      ridx;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [DATA_WIDTH-1:0] rd_capture;
  logic                  unused_addr_bits;

  // Word index drops the byte offset and wraps on the array size.
  assign widx = wr_addr[OFF +: IDX_W];
  assign ridx = rd_addr[OFF +: IDX_W];
  assign unused_addr_bits = ^{wr_addr[ADDR_WIDTH-1:OFF+IDX_W], wr_addr[OFF-1:0],
                              rd_addr[ADDR_WIDTH-1:OFF+IDX_W], rd_addr[OFF-1:0]};

  assign wr_cmd_rdy = !rst_q && !wr_stall;
  assign rd_cmd_rdy = !rst_q && !rd_stall && (outstanding < OUT_W'(MAX_OUTSTANDING));
  assign wr_acc     = (wr_datastrb != '0) && wr_cmd_rdy;
  assign rd_acc     = rd_en && rd_cmd_rdy;

  assign rd_data_vld = pipe_vld[RD_LATENCY-1];
  assign rd_data     = rd_data_vld ? pipe_dat[RD_LATENCY-1] : '0;

  always_comb begin
    rd_capture = mem[ridx];
    if (wr_acc && (widx == ridx)) begin
      for (int b = 0; b < MASK_WIDTH; b++) begin
        if (wr_datastrb[b]) rd_capture[b*8 +: 8] = wr_data[b*8 +: 8];
      end
    end
  end

  // Array is deliberately outside the reset domain so data survives rst.
  always_ff @(posedge clk) begin
    for (int b = 0; b < MASK_WIDTH; b++) begin
      if (wr_acc && wr_datastrb[b]) mem[widx][b*8 +: 8] <= wr_data[b*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    pipe_dat[0] <= rd_capture;
    for (int i = 1; i < RD_LATENCY; i++) pipe_dat[i] <= pipe_dat[i-1];
  end

  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      pipe_vld    <= '0;
      outstanding <= '0;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
    end else begin
      pipe_vld[0] <= rd_acc;
      for (int i = 1; i < RD_LATENCY; i++) pipe_vld[i] <= pipe_vld[i-1];
      case ({rd_acc, rd_data_vld})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      wr_cnt <= wr_cnt + 32'(wr_acc);
      rd_cnt <= rd_cnt + 32'(rd_data_vld);
    end
  end

endmodule

// File: tb/tb_host_mem_resp_model.sv
// Bench for host_mem_resp_model: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_host_mem_resp_model;

  localparam int DW = 64, AW = 64, MW = 8, DEPTH = 64, LAT = 4, MO = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] wr_data;
  logic [MW-1:0] wr_datastrb;
  logic [AW-1:0] wr_addr;
  logic          wr_cmd_rdy;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          rd_cmd_rdy;
  logic [DW-1:0] rd_data;
  logic          rd_data_vld;
  logic          wr_stall;
  logic          rd_stall;
  logic [31:0]   wr_cnt;
  logic [31:0]   rd_cnt;

  host_mem_resp_model #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MASK_WIDTH(MW), .DEPTH(DEPTH),
    .RD_LATENCY(LAT), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_datastrb(wr_datastrb), .wr_addr(wr_addr),
    .wr_cmd_rdy(wr_cmd_rdy), .rd_en(rd_en), .rd_addr(rd_addr), .rd_cmd_rdy(rd_cmd_rdy),
    .rd_data(rd_data), .rd_data_vld(rd_data_vld), .wr_stall(wr_stall), .rd_stall(rd_stall),
    .wr_cnt(wr_cnt), .rd_cnt(rd_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: word array, queue of pending returns with due cycle, counters.
  logic [DW-1:0] mmem [DEPTH];
  logic [DW-1:0] q_dat [$];
  int            q_due [$];
  bit            m_rstq;
  logic [31:0]   m_wcnt, m_rcnt;
  int            cyc;
  int            n_chk, n_pass;

  function automatic int widx_of(input logic [AW-1:0] a);
    return int'((a / 64'(MW)) % 64'(DEPTH));
  endfunction
  function automatic bit exp_wrdy();
    return !m_rstq && !wr_stall;
  endfunction
  function automatic bit exp_rrdy();
    return !m_rstq && !rd_stall && (q_due.size() < MO);
  endfunction
  function automatic bit exp_vld();
    return (q_due.size() > 0) && (q_due[0] == cyc);
  endfunction

  // Advance the model across the coming edge, then move to the next drive point.
  task automatic tick();
    bit wa, ra;
    int wi;
    wa = exp_wrdy() && (wr_datastrb != '0);
    ra = exp_rrdy() && rd_en;
    if (exp_vld()) begin
      void'(q_dat.pop_front());
      void'(q_due.pop_front());
      m_rcnt++;
    end
    if (wa) begin
      wi = widx_of(wr_addr);
      for (int b = 0; b < MW; b++) if (wr_datastrb[b]) mmem[wi][b*8 +: 8] = wr_data[b*8 +: 8];
    end
    if (rst) begin
      q_dat.delete();
      q_due.delete();
      m_wcnt = 0;
      m_rcnt = 0;
    end else begin
      if (wa) m_wcnt++;
      if (ra) begin
        q_dat.push_back(mmem[widx_of(rd_addr)]);
        q_due.push_back(cyc + LAT);
      end
    end
    m_rstq = rst;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    wr_data = '0; wr_datastrb = '0; wr_addr = '0; rd_en = 1'b0; rd_addr = '0;
    wr_stall = 1'b0; rd_stall = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] s);
    wr_addr = a; wr_data = d; wr_datastrb = s;
    tick();
    wr_datastrb = '0;
  endtask

  // Issue one read on an idle bus and wait (bounded) for its return; lat=-1 if none.
  task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output int lat);
    bit acc;
    lat = -1;
    d = '0;
    rd_en = 1'b1; rd_addr = a;
    @(negedge clk);
    acc = rd_cmd_rdy;
    tick();
    rd_en = 1'b0;
    if (!acc) return;
    for (int k = 1; k <= LAT + 6; k++) begin
      @(negedge clk);
      if (rd_data_vld) begin
        d = rd_data;
        lat = k;
        tick();
        return;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick(); tick();
    @(negedge clk);
    n_chk++; if (wr_cmd_rdy !== 1'b0) $display("FAIL rst_wrdy got %0b want 0", wr_cmd_rdy); else n_pass++;
    n_chk++; if (rd_cmd_rdy !== 1'b0) $display("FAIL rst_rrdy got %0b want 0", rd_cmd_rdy); else n_pass++;
    n_chk++; if (rd_data_vld !== 1'b0) $display("FAIL rst_vld got %0b want 0", rd_data_vld); else n_pass++;
    n_chk++; if (rd_data !== '0) $display("FAIL rst_data got %0h want 0", rd_data); else n_pass++;
    n_chk++; if (wr_cnt !== 32'd0) $display("FAIL rst_wcnt got %0d want 0", wr_cnt); else n_pass++;
    n_chk++; if (rd_cnt !== 32'd0) $display("FAIL rst_rcnt got %0d want 0", rd_cnt); else n_pass++;
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_chk++; if ({wr_cmd_rdy, rd_cmd_rdy} !== 2'b00) $display("FAIL rst_release_rdy got %b want 00", {wr_cmd_rdy, rd_cmd_rdy}); else n_pass++;
    tick();
    @(negedge clk);
    n_chk++; if ({wr_cmd_rdy, rd_cmd_rdy} !== 2'b11) $display("FAIL rst_after_rdy got %b want 11", {wr_cmd_rdy, rd_cmd_rdy}); else n_pass++;
    tick();
  endtask

  task automatic test_write_read();
    logic [DW-1:0] d;
    int lat;
    do_write(64'h40, 64'hDEAD_BEEF_0123_4567, 8'hFF);
    do_read(64'h40, d, lat);
    n_chk++; if (lat !== LAT) $display("FAIL wr_rd_latency got %0d want %0d", lat, LAT); else n_pass++;
    n_chk++; if (d !== 64'hDEAD_BEEF_0123_4567) $display("FAIL wr_rd_data got %0h want deadbeef01234567", d); else n_pass++;
    @(negedge clk);
    n_chk++; if (wr_cnt !== 32'd1) $display("FAIL wr_rd_wcnt got %0d want 1", wr_cnt); else n_pass++;
    n_chk++; if (rd_cnt !== 32'd1) $display("FAIL wr_rd_rcnt got %0d want 1", rd_cnt); else n_pass++;
    tick();
  endtask

  task automatic test_strobe();
    logic [DW-1:0] d;
    int lat;
    do_write(64'h0, '1, 8'hFF);
    do_write(64'h0, '0, 8'h01);
    do_write(64'h0, 64'h1234_5678_9ABC_DEF0, 8'h00);
    do_read(64'h0, d, lat);
    n_chk++; if (d !== 64'hFFFF_FFFF_FFFF_FF00) $display("FAIL strobe_data got %0h want ffffffffffffff00", d); else n_pass++;
    @(negedge clk);
    n_chk++; if (wr_cnt !== 32'd3) $display("FAIL strobe_wcnt got %0d want 3", wr_cnt); else n_pass++;
    tick();
  endtask

  task automatic fill_array();
    for (int i = 0; i < DEPTH; i++) do_write(64'(i * MW), {$urandom(), $urandom()}, 8'hFF);
  endtask

  task automatic test_outstanding();
    logic [AW-1:0] acc_addr [$];
    logic [DW-1:0] want;
    int n_acc, n_ret;
    bit prev_vld, b2b;
    n_acc = 0; n_ret = 0; prev_vld = 0; b2b = 0;
    for (int i = 0; i < 10 + LAT + 4; i++) begin
      rd_en = (i < 10);
      rd_addr = 64'((20 + i) * MW);
      @(negedge clk);
      n_chk++; if (rd_cmd_rdy && q_due.size() >= MO) $display("FAIL out_limit rdy=1 with %0d outstanding", q_due.size()); else n_pass++;
      if (rd_data_vld) begin
        want = (acc_addr.size() > 0) ? mmem[widx_of(acc_addr.pop_front())] : '0;
        n_chk++; if (rd_data !== want) $display("FAIL out_order got %0h want %0h", rd_data, want); else n_pass++;
        n_ret++;
        if (prev_vld) b2b = 1;
      end
      prev_vld = rd_data_vld;
      if (rd_en && rd_cmd_rdy) begin
        acc_addr.push_back(rd_addr);
        n_acc++;
      end
      tick();
    end
    n_chk++; if (n_acc !== 4) $display("FAIL out_accepts got %0d want 4", n_acc); else n_pass++;
    n_chk++; if (n_ret !== n_acc) $display("FAIL out_returns got %0d want %0d", n_ret, n_acc); else n_pass++;
    n_chk++; if (b2b !== 1'b1) $display("FAIL out_back_to_back got %0b want 1", b2b); else n_pass++;
  endtask

  task automatic test_same_cycle();
    logic [DW-1:0] d;
    int lat;
    bit got;
    got = 0;
    d = '0;
    do_write(64'(5 * MW), 64'hAAAA_BBBB_CCCC_DDDD, 8'hFF);
    wr_addr = 64'(5 * MW); wr_data = 64'h1111_2222_3333_4444; wr_datastrb = 8'h0F;
    rd_en = 1'b1; rd_addr = 64'(5 * MW);
    @(negedge clk);
    n_chk++; if ({wr_cmd_rdy, rd_cmd_rdy} !== 2'b11) $display("FAIL merge_rdy got %b want 11", {wr_cmd_rdy, rd_cmd_rdy}); else n_pass++;
    tick();
    idle();
    for (int k = 0; k < LAT + 6 && !got; k++) begin
      @(negedge clk);
      if (rd_data_vld) begin got = 1; d = rd_data; end
      tick();
    end
    n_chk++; if (d !== 64'hAAAA_BBBB_3333_4444) $display("FAIL merge_data got %0h want aaaabbbb33334444", d); else n_pass++;
    do_write(64'(DEPTH * MW), 64'h0A1A_5E5E_C0DE_F00D, 8'hFF);
    do_read(64'h0, d, lat);
    n_chk++; if (d !== 64'h0A1A_5E5E_C0DE_F00D) $display("FAIL alias_data got %0h want 0a1a5e5ec0def00d", d); else n_pass++;
  endtask

  task automatic test_reset_in_flight();
    logic [DW-1:0] d;
    int lat, n_vld;
    n_vld = 0;
    do_write(64'(7 * MW), 64'h7777_0000_CAFE_BABE, 8'hFF);
    rd_en = 1'b1; rd_addr = 64'(2 * MW);
    tick(); tick(); tick();
    rd_en = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_chk++; if ({wr_cmd_rdy, rd_cmd_rdy} !== 2'b00) $display("FAIL rstfl_rdy got %b want 00", {wr_cmd_rdy, rd_cmd_rdy}); else n_pass++;
    n_chk++; if (wr_cnt !== 32'd0 || rd_cnt !== 32'd0) $display("FAIL rstfl_cnt got %0d/%0d want 0/0", wr_cnt, rd_cnt); else n_pass++;
    for (int k = 0; k < LAT + 4; k++) begin
      if (k > 0) @(negedge clk);
      if (rd_data_vld) n_vld++;
      if (k == 1) begin
        n_chk++; if ({wr_cmd_rdy, rd_cmd_rdy} !== 2'b11) $display("FAIL rstfl_rdy_back got %b want 11", {wr_cmd_rdy, rd_cmd_rdy}); else n_pass++;
      end
      tick();
    end
    n_chk++; if (n_vld !== 0) $display("FAIL rstfl_dropped got %0d returns want 0", n_vld); else n_pass++;
    do_read(64'(7 * MW), d, lat);
    n_chk++; if (d !== 64'h7777_0000_CAFE_BABE) $display("FAIL rstfl_persist got %0h want 77770000cafebabe", d); else n_pass++;
    n_chk++; if (lat !== LAT) $display("FAIL rstfl_latency got %0d want %0d", lat, LAT); else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 410; i++) begin
      if (i < 400) begin
        wr_stall = 1'($urandom());
        rd_stall = 1'($urandom());
        wr_datastrb = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom());
        wr_data = {$urandom(), $urandom()};
        wr_addr = {$urandom(), $urandom()};
        rd_en = 1'($urandom());
        rd_addr = ($urandom_range(0, 1) == 0) ? wr_addr : {$urandom(), $urandom()};
      end else idle();
      @(negedge clk);
      n_chk++; if (wr_cmd_rdy !== exp_wrdy()) $display("FAIL rnd_wrdy cyc %0d got %0b want %0b", cyc, wr_cmd_rdy, exp_wrdy()); else n_pass++;
      n_chk++; if (rd_cmd_rdy !== exp_rrdy()) $display("FAIL rnd_rrdy cyc %0d got %0b want %0b", cyc, rd_cmd_rdy, exp_rrdy()); else n_pass++;
      n_chk++; if (rd_data_vld !== exp_vld()) $display("FAIL rnd_vld cyc %0d got %0b want %0b", cyc, rd_data_vld, exp_vld()); else n_pass++;
      if (exp_vld()) begin
        n_chk++; if (rd_data !== q_dat[0]) $display("FAIL rnd_data cyc %0d got %0h want %0h", cyc, rd_data, q_dat[0]); else n_pass++;
      end else begin
        n_chk++; if (rd_data !== '0) $display("FAIL rnd_idle_data cyc %0d got %0h want 0", cyc, rd_data); else n_pass++;
      end
      n_chk++; if (wr_cnt !== m_wcnt || rd_cnt !== m_rcnt) $display("FAIL rnd_cnt cyc %0d got %0d/%0d want %0d/%0d", cyc, wr_cnt, rd_cnt, m_wcnt, m_rcnt); else n_pass++;
      tick();
    end
  endtask

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0;
    m_rstq = 1'b0; m_wcnt = '0; m_rcnt = '0;
    rst = 1'b1;
    idle();
    test_reset();
    test_write_read();
    test_strobe();
    fill_array();
    test_outstanding();
    test_same_cycle();
    test_reset_in_flight();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
